// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// operand width, operation codes and controller state encoding.
package hilo_pkg;

  localparam int W = 32;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MFHI  = 4'd7,
    MFLO  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    MUL_WAIT = 2'd2,
    DRAIN    = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_mult.sv
// Registered 32x32 multiplier; one 64-bit product shared by MULT and MULTU.
module hilo_mult
  import hilo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           is_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  logic [2*W-1:0] product_d, product_q;
  logic [2*W-1:0] ext_a, ext_b;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then correct for both signed and unsigned operands.
  assign ext_a = {{W{is_signed & a[W-1]}}, a};
  assign ext_b = {{W{is_signed & b[W-1]}}, b};

  always_comb begin
    product_d = product_q;
    if (load) product_d = ext_a * ext_b;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) product_q <= '0;
    else     product_q <= product_d;
  end

  assign product = product_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO issue/writeback controller: launches divides, runs multiplies locally,
// owns HI/LO, serves MFHI/MFLO and drains divides killed by a flush.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [3:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] rdata,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic         div0,
  output logic         div_en,
  output logic         div_hassign,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_busy,
  input  logic         div_done,
  input  logic         div_overflow
);

  state_e         state_d, state_q;
  logic [W-1:0]   hi_d, hi_q, lo_d, lo_q;
  logic           div0_d, div0_q;
  logic           mul_load, mul_signed;
  logic [2*W-1:0] product;
  op_e            op_i;
  logic           unused_busy;

  assign op_i        = op_e'(op);
  assign unused_busy = div_busy;
  assign div_a       = src_a;
  assign div_b       = src_b;

  hilo_mult u_mult (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .is_signed (mul_signed),
    .a         (src_a),
    .b         (src_b),
    .product   (product)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    div0_d      = 1'b0;
    stall       = 1'b0;
    div_en      = 1'b0;
    div_hassign = 1'b0;
    mul_load    = 1'b0;
    mul_signed  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          unique case (op_i)
            DIV, DIVU: begin
              div_en      = 1'b1;
              div_hassign = (op_i == DIV);
              stall       = 1'b1;
              state_d     = DIV_WAIT;
            end
            MULT, MULTU: begin
              mul_load   = 1'b1;
              mul_signed = (op_i == MULT);
              stall      = 1'b1;
              state_d    = MUL_WAIT;
            end
            MTHI:    hi_d = src_a;
            MTLO:    lo_d = src_a;
            default: ;
          endcase
        end
      end
      DIV_WAIT: begin
        stall = ~div_done;
        if (flush) begin
          // The divider cannot be aborted: finish it silently in DRAIN.
          stall   = 1'b0;
          state_d = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          hi_d    = div_r;
          lo_d    = div_q;
          div0_d  = div_overflow;
          state_d = IDLE;
        end
      end
      MUL_WAIT: begin
        if (!flush) {hi_d, lo_d} = product;
        state_d = IDLE;
      end
      DRAIN: begin
        // A new instruction waits here and is executed once back in IDLE.
        stall = op_valid & ~flush;
        if (div_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (op_i == MFHI)      rdata = hi_q;
    else if (op_i == MFLO) rdata = lo_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a behavioural divider of
// programmable latency; expected values are hand-computed constants.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall;
  logic [31:0] rdata, hi_o, lo_o;
  logic        div0, div_en, div_hassign;
  logic [31:0] div_a, div_b;
  logic [31:0] div_q, div_r;
  logic        div_busy, div_done, div_overflow;

  int n_asserts = 0;
  int n_fail    = 0;
  int div_lat   = 0;
  int div_cnt;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .stall        (stall),
    .rdata        (rdata),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div0         (div0),
    .div_en       (div_en),
    .div_hassign  (div_hassign),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_q        (div_q),
    .div_r        (div_r),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_overflow (div_overflow)
  );

  // Divider model: done arrives div_lat+1 cycles after the div_en cycle
  // (div_lat = 0 is the early-out case, done in the very next cycle).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= 0;
      div_done     <= 1'b0;
      div_q        <= '0;
      div_r        <= '0;
      div_overflow <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_en) begin
        if (div_b == 32'd0) begin
          div_q        <= 32'hFFFF_FFFF;
          div_r        <= 32'd0;
          div_overflow <= 1'b1;
        end else if (div_hassign) begin
          div_q        <= $signed(div_a) / $signed(div_b);
          div_r        <= $signed(div_a) % $signed(div_b);
          div_overflow <= 1'b0;
        end else begin
          div_q        <= div_a / div_b;
          div_r        <= div_a % div_b;
          div_overflow <= 1'b0;
        end
        if (div_lat == 0) div_done <= 1'b1;
        else              div_cnt  <= div_lat;
      end else if (div_cnt == 1) begin
        div_done <= 1'b1;
        div_cnt  <= 0;
      end else if (div_cnt > 1) begin
        div_cnt <= div_cnt - 1;
      end
    end
  end

  assign div_busy = (div_cnt != 0);

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input op_e o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op       = NONE;
    src_a    = '0;
    src_b    = '0;
  endtask

  // Advance to the next negedge and let combinational outputs settle.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check32("rst_hi", hi_o, 32'h0);
    check32("rst_lo", lo_o, 32'h0);
    check1("rst_stall", stall, 1'b0);
    check1("rst_div_en", div_en, 1'b0);
    check1("rst_div0", div0, 1'b0);
    check32("rst_state", 32'(dut.state_q), 32'(IDLE));
    check32("rst_prod_lo", dut.u_mult.product_q[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // DIV -7 / 2, divider takes 4 cycles after issue
    div_lat = 3;
    @(negedge clk); drive(DIV, 32'hFFFF_FFF9, 32'd2); #1;
    check1("div_en_issue", div_en, 1'b1);
    check1("div_stall_issue", stall, 1'b1);
    check1("div_hassign", div_hassign, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check1("div_wait_stall", stall, 1'b1);
      check1("div_wait_no_en", div_en, 1'b0);
    end
    cyc();
    check1("div_done_stall", stall, 1'b0);
    @(negedge clk); drive(MFLO, 32'h0, 32'h0); #1;
    check32("div_lo", lo_o, 32'hFFFF_FFFD);
    check32("div_hi", hi_o, 32'hFFFF_FFFF);
    check1("div_div0", div0, 1'b0);
    check32("div_mflo", rdata, 32'hFFFF_FFFD);
    check1("div_mflo_stall", stall, 1'b0);

    // MULTU then MULT of FFFFFFFF * 2
    @(negedge clk); drive(MULTU, 32'hFFFF_FFFF, 32'd2); #1;
    check1("multu_stall", stall, 1'b1);
    check1("multu_no_div_en", div_en, 1'b0);
    cyc();
    check1("multu_wait_stall", stall, 1'b0);
    @(negedge clk); drive(MULT, 32'hFFFF_FFFF, 32'd2); #1;
    check32("multu_hi", hi_o, 32'h0000_0001);
    check32("multu_lo", lo_o, 32'hFFFF_FFFE);
    check1("mult_stall", stall, 1'b1);
    cyc();
    check1("mult_wait_stall", stall, 1'b0);
    @(negedge clk); idle(); #1;
    check32("mult_hi", hi_o, 32'hFFFF_FFFF);
    check32("mult_lo", lo_o, 32'hFFFF_FFFE);

    // DIVU 5 / 0
    div_lat = 2;
    @(negedge clk); drive(DIVU, 32'd5, 32'd0); #1;
    check1("divu0_hassign", div_hassign, 1'b0);
    check1("divu0_stall", stall, 1'b1);
    cyc(); check1("divu0_wait1", stall, 1'b1);
    cyc(); check1("divu0_wait2", stall, 1'b1);
    cyc(); check1("divu0_done", stall, 1'b0);
    @(negedge clk); idle(); #1;
    check32("divu0_lo", lo_o, 32'hFFFF_FFFF);
    check32("divu0_hi", hi_o, 32'h0);
    check1("divu0_div0_pulse", div0, 1'b1);
    cyc();
    check1("divu0_div0_clear", div0, 1'b0);

    // DIVU 3 / 9 with early-out divider
    div_lat = 0;
    @(negedge clk); drive(DIVU, 32'd3, 32'd9); #1;
    check1("early_en", div_en, 1'b1);
    cyc();
    check1("early_done_stall", stall, 1'b0);
    @(negedge clk); idle(); #1;
    check32("early_lo", lo_o, 32'h0);
    check32("early_hi", hi_o, 32'h3);
    check1("early_div0", div0, 1'b0);

    // MTHI / MTLO then MFHI
    @(negedge clk); drive(MTHI, 32'h1234_5678, 32'h0); #1;
    check1("mthi_stall", stall, 1'b0);
    @(negedge clk); drive(MTLO, 32'hAAAA_5555, 32'h0); #1;
    check1("mtlo_stall", stall, 1'b0);
    @(negedge clk); drive(MFHI, 32'h0, 32'h0); #1;
    check32("mfhi_rdata", rdata, 32'h1234_5678);
    check1("mfhi_stall", stall, 1'b0);

    // Flush in IDLE blocks the write
    @(negedge clk); drive(MTHI, 32'hDEAD_BEEF, 32'h0); flush = 1'b1; #1;
    check1("idle_flush_stall", stall, 1'b0);
    @(negedge clk); flush = 1'b0; idle(); #1;
    check32("idle_flush_hi", hi_o, 32'h1234_5678);

    // Flush three cycles into a DIV; MFLO waits out the drain
    div_lat = 6;
    @(negedge clk); drive(DIV, 32'd100, 32'd3); #1;
    check1("fl_issue_stall", stall, 1'b1);
    cyc(); cyc();
    @(negedge clk); flush = 1'b1; #1;
    check1("fl_flush_stall", stall, 1'b0);
    @(negedge clk); flush = 1'b0; drive(MFLO, 32'h0, 32'h0); #1;
    check32("fl_state_drain", 32'(dut.state_q), 32'(DRAIN));
    check1("fl_drain_stall4", stall, 1'b1);
    check1("fl_drain_no_en", div_en, 1'b0);
    cyc(); check1("fl_drain_stall5", stall, 1'b1);
    cyc(); check1("fl_drain_stall6", stall, 1'b1);
    cyc(); check1("fl_drain_stall_done", stall, 1'b1);
    cyc();
    check32("fl_state_idle", 32'(dut.state_q), 32'(IDLE));
    check1("fl_mflo_stall", stall, 1'b0);
    check32("fl_mflo_rdata", rdata, 32'hAAAA_5555);
    check32("fl_hi_kept", hi_o, 32'h1234_5678);
    check1("fl_div0", div0, 1'b0);
    @(negedge clk); idle(); #1;
    check32("fl_lo_kept", lo_o, 32'hAAAA_5555);
    check1("fl_div0_after", div0, 1'b0);

    // Flush in the same cycle as div_done
    div_lat = 0;
    @(negedge clk); drive(DIVU, 32'd50, 32'd0); #1;
    @(negedge clk); flush = 1'b1; #1;
    check1("fl_done_stall", stall, 1'b0);
    @(negedge clk); flush = 1'b0; idle(); #1;
    check32("fl_done_state", 32'(dut.state_q), 32'(IDLE));
    check32("fl_done_lo", lo_o, 32'hAAAA_5555);
    check1("fl_done_div0", div0, 1'b0);

    // Flush in MUL_WAIT
    @(negedge clk); drive(MULTU, 32'd3, 32'd4); #1;
    @(negedge clk); flush = 1'b1; #1;
    @(negedge clk); flush = 1'b0; idle(); #1;
    check32("fl_mul_hi", hi_o, 32'h1234_5678);
    check32("fl_mul_lo", lo_o, 32'hAAAA_5555);
    check32("fl_mul_state", 32'(dut.state_q), 32'(IDLE));

    // Reset during DIV_WAIT, then DIVU 100 / 7
    div_lat = 5;
    @(negedge clk); drive(DIV, 32'd9, 32'd2); #1;
    cyc(); cyc();
    rst = 1'b1; idle(); #1;
    check32("rst2_hi", hi_o, 32'h0);
    check32("rst2_lo", lo_o, 32'h0);
    check1("rst2_stall", stall, 1'b0);
    check32("rst2_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk); rst = 1'b0;
    div_lat = 1;
    @(negedge clk); drive(DIVU, 32'd100, 32'd7); #1;
    check1("post_rst_en", div_en, 1'b1);
    cyc(); check1("post_rst_wait", stall, 1'b1);
    cyc(); check1("post_rst_done", stall, 1'b0);
    @(negedge clk); idle(); #1;
    check32("post_rst_lo", lo_o, 32'd14);
    check32("post_rst_hi", hi_o, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Issue/writeback controller between the EX stage and the multi-cycle divider. Decodes HI/LO-class instructions, launches divides, and runs signed and unsigned multiplies in a local registered multiplier. Owns the architectural HI/LO registers, serves MFHI/MFLO reads, and generates the pipeline stall. Handles flushes while a divide is in flight; the divider has no abort input, so a flushed divide is drained and its result discarded.

Parameters:
- W, 32, operand/HI/LO width (only 32 supported; divider is fixed-width)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  EX holds a HI/LO-class instruction (held high while stalled)
- op  in  4  operation code (package enum)
- src_a  in  32  rs value
- src_b  in  32  rt value
- flush  in  1  kill the EX instruction and any in-flight op
- stall  out  1  hold EX and earlier stages
- rdata  out  32  MFHI/MFLO result (combinational from HI/LO)
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- div0  out  1  one-cycle pulse when a divide-by-zero result is committed
- div_en  out  1  divider start pulse
- div_hassign  out  1  1 = DIV, 0 = DIVU
- div_a  out  32  dividend (= src_a)
- div_b  out  32  divisor (= src_b)
- div_q  in  32  quotient
- div_r  in  32  remainder
- div_busy  in  1  divider busy (monitor only)
- div_done  in  1  divider one-cycle done pulse
- div_overflow  in  1  divide-by-zero flag, valid with div_done

Behaviour:
- Reset: state=IDLE; hi_o=lo_o=0; stall=0; div_en=0; div0=0; product register=0. Reset mid-operation returns to IDLE immediately. The divider is reset by the same rst.
- States: IDLE, DIV_WAIT, MUL_WAIT, DRAIN.
- IDLE, op_valid=1, flush=0:
  - DIV/DIVU: div_en=1 (combinational, this cycle only); div_hassign per op; stall=1; next state DIV_WAIT.
  - MULT/MULTU: 64-bit product registered at this edge (signed or unsigned); stall=1; next state MUL_WAIT.
  - MTHI/MTLO: HI (or LO) <= src_a at this edge; no stall.
  - MFHI/MFLO: rdata = hi_o (or lo_o); no stall. rdata = 0 for any other op.
- IDLE with flush=1: no issue, no write, no stall.
- DIV_WAIT:
  - stall = ~div_done; op_valid is ignored (it is the held instruction).
  - On div_done: HI <= div_r, LO <= div_q; div0 <= div_overflow (div0 asserts the following cycle); next state IDLE.
  - div_done may arrive as early as the cycle after div_en (divider early-out path). This must work.
- MUL_WAIT: stall=0; {HI,LO} <= product; next state IDLE. Issue-to-commit is 2 cycles.
- Flush in DIV_WAIT without div_done: stall=0; next state DRAIN. Flush in the same cycle as div_done: result discarded, next state IDLE.
- Flush in MUL_WAIT: no commit; next state IDLE.
- DRAIN: on div_done, discard the result (no HI/LO write, no div0); next state IDLE. Any valid op seen in DRAIN gets stall=1 and is not executed; IDLE picks it up afterwards.
- Division by zero commits the divider's values: LO=FFFFFFFF, HI=0.
- MFHI/MFLO in the cycle after commit sees the new value. HI/LO are registered, so there is no same-cycle forwarding.
- div_a/div_b are driven combinationally from src_a/src_b; only the div_en cycle is meaningful.
- Never assert div_en outside IDLE.

Decomposition:
- Package hilo_pkg:
  - 4-bit op enum: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8
  - state encoding
  - W constant
- Sub-module hilo_mult: registered 32x32 multiplier with a signed select and a load enable, producing a 64-bit product.

Test Plan:
- DIV a=FFFFFFF9 (-7), b=2, with divider model → stall held until done; then LO=FFFFFFFD, HI=FFFFFFFF, div0=0. Next-cycle MFLO rdata=FFFFFFFD.
- MULTU a=FFFFFFFF, b=2 → stall for exactly 1 cycle; HI=00000001, LO=FFFFFFFE. MULT with the same operands → HI=FFFFFFFF, LO=FFFFFFFE.
- DIVU a=5, b=0 → LO=FFFFFFFF, HI=0; div0 pulses exactly one cycle. DIVU a=3, b=9 (early-out, done the next cycle) → LO=0, HI=3.
- MTHI 12345678, then MFHI the next cycle → rdata=12345678, stall never asserted.
- Flush 3 cycles into a DIV → stall drops the same cycle; state DRAIN. MFLO issued meanwhile stalls until div_done. HI/LO keep their prior values and div0 stays 0.
- Reset asserted during DIV_WAIT → hi_o=lo_o=0, stall=0, state IDLE. A DIVU 100/7 issued after reset → LO=14, HI=2.
